daq_event_buffer: RTL and testbench

- Consumes the DAQ word stream (daq_write/daq_data) produced by the trigger block's soft TBM.
- Frames words into events using header/trailer markers and admits whole events only.
- Stores events in a first-word-fall-through FIFO and presents them to the DAQ DMA/readout side over valid/ready with sop/eop.
- Reports stored and dropped event counts to the control interface.

---
 rtl/daq_evbuf_pkg.sv | 25 ++
 rtl/daq_evbuf_fifo.sv | 79 +++++++
 rtl/daq_event_buffer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_daq_event_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/daq_evbuf_pkg.sv
// rtl/daq_evbuf_pkg.sv - shared types and constants for the DAQ event buffer
//
// Purpose: marker bit positions of the DAQ word, the framing FSM state
// encoding, and the layout of one FIFO entry {eop, sop, data[15:0]}.
// Ports: none (package).

package daq_evbuf_pkg;

    localparam int DATA_W  = 16;
    localparam int HDR_BIT = 15;
    localparam int TRL_BIT = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STORE   = 2'd1,
        DISCARD = 2'd2
    } evbuf_state_e;

    typedef struct packed {
        logic              eop;
        logic              sop;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/daq_evbuf_fifo.sv
// rtl/daq_evbuf_fifo.sv - first-word-fall-through FIFO with occupancy count
//
// Purpose: 2**DEPTH_LOG2-entry FIFO; the head entry is presented
// combinationally from the storage array, so a written word becomes visible
// on the cycle after the write.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset (pointers/count)
//   wr_en_i, wr_entry_i     push one entry (ignored when full)
//   rd_en_i                 pop the head entry (ignored when empty)
//   rd_valid_o, rd_entry_o  head entry present / head entry
//   count_o                 current occupancy, 0..2**DEPTH_LOG2

module daq_evbuf_fifo
    import daq_evbuf_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en_i,
    input  fifo_entry_t         wr_entry_i,
    input  logic                rd_en_i,
    output logic                rd_valid_o,
    output fifo_entry_t         rd_entry_o,
    output logic [DEPTH_LOG2:0] count_o
);

    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    fifo_entry_t           mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_wr, do_rd;

    assign do_wr = wr_en_i && (count_q != DEPTH);
    assign do_rd = rd_en_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_entry_i;
        end
    end

    assign rd_valid_o = (count_q != '0);
    assign rd_entry_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/daq_event_buffer.sv
// rtl/daq_event_buffer.sv - frames the DAQ word stream into whole events and buffers them
//
// Purpose: samples daq_data on sync&&daq_write, frames events on header
// (bit15) / trailer (bit14) markers, admits an event only when the FIFO has
// room for a worst-case event, truncates over-long events, and presents the
// stored words over valid/ready with sop/eop. Counts stored/dropped events.
// Optional feature macro: DAQ_EVBUF_TIMESTAMP_EN inserts two timestamp words
// (high half, low half) after each admitted multi-word header.
// Ports:
//   clk, reset_n                 80 MHz clock, asynchronous active-low reset
//   sync, daq_write, daq_data    input word stream, qualified by sync
//   enable                       0 = new events silently discarded
//   out_valid/out_ready          head-word handshake
//   out_data/out_sop/out_eop     head word and its framing flags
//   ev_count, drop_count         stored (wrapping) / dropped (saturating) events
//   overflow, clr_stat           sticky drop flag / clear of all statistics
//   fill_level                   FIFO occupancy

module daq_event_buffer
    import daq_evbuf_pkg::*;
#(
    parameter int DEPTH_LOG2      = 10,
    parameter int MAX_EVENT_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync,
    input  logic                  enable,
    input  logic                  daq_write,
    input  logic [DATA_W-1:0]     daq_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [15:0]           ev_count,
    output logic [15:0]           drop_count,
    output logic                  overflow,
    input  logic                  clr_stat,
    output logic [DEPTH_LOG2:0]   fill_level
);

`ifdef DAQ_EVBUF_TIMESTAMP_EN
    localparam int TS_WORDS = 2;
`else
    localparam int TS_WORDS = 0;
`endif

    localparam int                  CW       = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]       DEPTH    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CW-1:0]       NEED     = CW'(MAX_EVENT_WORDS + TS_WORDS);
    localparam logic [CW-1:0]       LAST_CNT = CW'(MAX_EVENT_WORDS - 1);

    evbuf_state_e      state_q, state_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [15:0]       ev_count_q, ev_count_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic              overflow_q, overflow_d;

    logic              acc;
    logic              w_vld;
    logic [DATA_W-1:0] w_data;
    logic              ts_busy;
    logic [DATA_W-1:0] ts_word;

    logic              wr_en;
    fifo_entry_t       wr_entry;
    fifo_entry_t       head;
    logic              head_vld;
    logic [CW-1:0]     fill;
    logic              fits;
    logic              take_hdr;
    logic              ev_inc;
    logic [1:0]        drop_add;
    logic [16:0]       drop_sum;

    assign acc  = sync && daq_write;
    assign fits = ((DEPTH - fill) >= NEED);

`ifdef DAQ_EVBUF_TIMESTAMP_EN
    // While the two timestamp words occupy the write port, an input word is
    // parked in hold_q and processed on the next free cycle.
    logic [31:0]       ts_q, ts_lat_q;
    logic [1:0]        ts_pend_q;
    logic [DATA_W-1:0] hold_q;
    logic              hold_vld_q;
    logic              ts_start;

    assign ts_busy = (ts_pend_q != 2'd0);
    assign ts_word = (ts_pend_q == 2'd2) ? ts_lat_q[31:16] : ts_lat_q[15:0];
    assign w_vld   = hold_vld_q || acc;
    assign w_data  = hold_vld_q ? hold_q : daq_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q       <= '0;
            ts_lat_q   <= '0;
            ts_pend_q  <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            if (sync) begin
                ts_q <= ts_q + 32'd1;
            end
            if (ts_start) begin
                ts_lat_q  <= ts_q;
                ts_pend_q <= 2'd2;
            end else if (ts_busy) begin
                ts_pend_q <= ts_pend_q - 2'd1;
            end
            if (ts_busy) begin
                if (acc) begin
                    hold_vld_q <= 1'b1;
                    hold_q     <= daq_data;
                end
            end else if (hold_vld_q) begin
                hold_vld_q <= acc;
                if (acc) begin
                    hold_q <= daq_data;
                end
            end
        end
    end
`else
    assign ts_busy = 1'b0;
    assign ts_word = '0;
    assign w_vld   = acc;
    assign w_data  = daq_data;
`endif

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        wr_en      = 1'b0;
        wr_entry   = '0;
        take_hdr   = 1'b0;
        ev_inc     = 1'b0;
        drop_add   = 2'd0;
`ifdef DAQ_EVBUF_TIMESTAMP_EN
        ts_start   = 1'b0;
`endif
        if (ts_busy) begin
            wr_en         = 1'b1;
            wr_entry.data = ts_word;
        end else if (w_vld) begin
            case (state_q)
                STORE: begin
                    if (w_data[HDR_BIT]) begin
                        // Open event is closed without eop; the header is
                        // then admitted like a fresh one.
                        drop_add = 2'd1;
                        take_hdr = 1'b1;
                    end else begin
                        wr_en         = 1'b1;
                        wr_entry.data = w_data;
                        if (w_data[TRL_BIT]) begin
                            wr_entry.eop = 1'b1;
                            ev_inc       = 1'b1;
                            state_d      = IDLE;
                        end else if (word_cnt_q == LAST_CNT) begin
                            wr_entry.eop           = 1'b1;
                            wr_entry.data[TRL_BIT] = 1'b1;
                            drop_add               = 2'd1;
                            state_d                = DISCARD;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (w_data[HDR_BIT]) begin
                        take_hdr = 1'b1;
                    end else if (w_data[TRL_BIT]) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    if (w_data[HDR_BIT]) begin
                        take_hdr = 1'b1;
                    end
                end
            endcase

            if (take_hdr) begin
                if (enable && fits) begin
                    wr_en         = 1'b1;
                    wr_entry.sop  = 1'b1;
                    wr_entry.eop  = w_data[TRL_BIT];
                    wr_entry.data = w_data;
                    if (w_data[TRL_BIT]) begin
                        ev_inc  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        word_cnt_d = CW'(1);
                        state_d    = STORE;
`ifdef DAQ_EVBUF_TIMESTAMP_EN
                        ts_start   = 1'b1;
`endif
                    end
                end else begin
                    if (enable) begin
                        drop_add = drop_add + 2'd1;
                    end
                    // A rejected single-word event is already complete.
                    state_d = w_data[TRL_BIT] ? IDLE : DISCARD;
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop_count_q} + {15'd0, drop_add};

    always_comb begin
        ev_count_d   = ev_count_q;
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (clr_stat) begin
            ev_count_d   = '0;
            drop_count_d = '0;
            overflow_d   = 1'b0;
        end else begin
            if (ev_inc) begin
                ev_count_d = ev_count_q + 16'd1;
            end
            drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (drop_add != 2'd0) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            ev_count_q   <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            ev_count_q   <= ev_count_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    daq_evbuf_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en_i    (wr_en),
        .wr_entry_i (wr_entry),
        .rd_en_i    (out_ready),
        .rd_valid_o (head_vld),
        .rd_entry_o (head),
        .count_o    (fill)
    );

    // Head fields are masked while empty so the outputs read 0, not stale RAM.
    assign out_valid  = head_vld;
    assign out_data   = head_vld ? head.data : '0;
    assign out_sop    = head_vld && head.sop;
    assign out_eop    = head_vld && head.eop;
    assign fill_level = fill;
    assign ev_count   = ev_count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_daq_event_buffer.sv
// tb/tb_daq_event_buffer.sv - directed self-checking bench for daq_event_buffer

module tb_daq_event_buffer;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0, rst_b = 1'b0;
    logic        sync = 1'b0, enable = 1'b1, daq_write = 1'b0, clr_stat = 1'b0;
    logic [15:0] daq_data = '0;
    logic        rdy_a = 1'b1, rdy_b = 1'b0;

    logic        out_valid_a, out_sop_a, out_eop_a, overflow_a;
    logic [15:0] out_data_a, ev_a, drop_a;
    logic [10:0] fill_a;
    logic        out_valid_b, out_sop_b, out_eop_b, overflow_b;
    logic [15:0] out_data_b, ev_b, drop_b;
    logic [4:0]  fill_b;

    logic [17:0] q_a[$];
    logic [17:0] q_b[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    daq_event_buffer u_dut (
        .clk(clk), .reset_n(rst_a), .sync(sync), .enable(enable),
        .daq_write(daq_write), .daq_data(daq_data),
        .out_valid(out_valid_a), .out_ready(rdy_a), .out_data(out_data_a),
        .out_sop(out_sop_a), .out_eop(out_eop_a),
        .ev_count(ev_a), .drop_count(drop_a), .overflow(overflow_a),
        .clr_stat(clr_stat), .fill_level(fill_a)
    );

    daq_event_buffer #(.DEPTH_LOG2(4), .MAX_EVENT_WORDS(8)) u_small (
        .clk(clk), .reset_n(rst_b), .sync(sync), .enable(enable),
        .daq_write(daq_write), .daq_data(daq_data),
        .out_valid(out_valid_b), .out_ready(rdy_b), .out_data(out_data_b),
        .out_sop(out_sop_b), .out_eop(out_eop_b),
        .ev_count(ev_b), .drop_count(drop_b), .overflow(overflow_b),
        .clr_stat(clr_stat), .fill_level(fill_b)
    );

    // Popped words {eop, sop, data}, sampled between edges.
    always @(negedge clk) begin
        #1;
        if (out_valid_a && rdy_a) q_a.push_back({out_eop_a, out_sop_a, out_data_a});
        if (out_valid_b && rdy_b) q_b.push_back({out_eop_b, out_sop_b, out_data_b});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d);
        @(negedge clk);
        sync = 1'b1; daq_write = 1'b1; daq_data = d;
        @(negedge clk);
        sync = 1'b0; daq_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [17:0] qa_at(input int i);
        return (i < q_a.size()) ? q_a[i] : 18'h3FFFF;
    endfunction

    function automatic logic [17:0] qb_at(input int i);
        return (i < q_b.size()) ? q_b[i] : 18'h3FFFF;
    endfunction

    initial begin
        logic [15:0] d;
        logic [17:0] e;

        // reset state
        idle(2);
        chk("rst_valid", 32'(out_valid_a), 32'd0);
        chk("rst_data",  32'(out_data_a),  32'd0);
        chk("rst_fill",  32'(fill_a),      32'd0);
        chk("rst_ev",    32'(ev_a),        32'd0);
        chk("rst_drop",  32'(drop_a),      32'd0);
        chk("rst_ovf",   32'(overflow_a),  32'd0);
        @(negedge clk) rst_a = 1'b1;

        // basic three-word event
        send(16'h8001); send(16'h0123); send(16'h4002); idle(4);
        chk("t1_size", 32'(q_a.size()), 32'd3);
        chk("t1_w0",   32'(qa_at(0)), 32'h0_8001 | 32'h1_0000);
        chk("t1_w1",   32'(qa_at(1)), 32'h0_0123);
        chk("t1_w2",   32'(qa_at(2)), 32'h2_4002);
        chk("t1_ev",   32'(ev_a),     32'd1);
        chk("t1_drop", 32'(drop_a),   32'd0);
        q_a.delete();

        // single-word event
        send(16'hC0AB); idle(4);
        chk("t2_size", 32'(q_a.size()), 32'd1);
        chk("t2_w0",   32'(qa_at(0)), 32'h3_C0AB);
        chk("t2_ev",   32'(ev_a),     32'd2);
        q_a.delete();

        // strobes without sync are ignored
        @(negedge clk); sync = 1'b0; daq_write = 1'b1; daq_data = 16'hC0CD;
        idle(4); daq_write = 1'b0; idle(2);
        chk("t3_size", 32'(q_a.size()), 32'd0);
        chk("t3_ev",   32'(ev_a),       32'd2);
        chk("t3_fill", 32'(fill_a),     32'd0);

        // header inside an open event
        send(16'h8010); send(16'h0011); send(16'h0012);
        send(16'h8020); send(16'h0021); send(16'h4022); idle(4);
        chk("t4_size", 32'(q_a.size()), 32'd6);
        chk("t4_w2",   32'(qa_at(2)), 32'h0_0012);
        chk("t4_w3",   32'(qa_at(3)), 32'h1_8020);
        chk("t4_w5",   32'(qa_at(5)), 32'h2_4022);
        chk("t4_ev",   32'(ev_a),       32'd3);
        chk("t4_drop", 32'(drop_a),     32'd1);
        chk("t4_ovf",  32'(overflow_a), 32'd1);
        q_a.delete();

        // enable=0 discards silently; an event in progress completes
        enable = 1'b0;
        send(16'h8030); send(16'h0031); send(16'h4032); idle(4);
        chk("t5_size", 32'(q_a.size()), 32'd0);
        chk("t5_drop", 32'(drop_a),     32'd1);
        chk("t5_ev",   32'(ev_a),       32'd3);
        enable = 1'b1;
        send(16'h8040);
        enable = 1'b0;
        send(16'h0041); send(16'h4042);
        enable = 1'b1;
        idle(4);
        chk("t5b_size", 32'(q_a.size()), 32'd3);
        chk("t5b_w2",   32'(qa_at(2)), 32'h2_4042);
        chk("t5b_ev",   32'(ev_a),     32'd4);
        q_a.delete();

        // clear coinciding with a trailer: clear wins
        send(16'h8050); send(16'h0051);
        @(negedge clk); sync = 1'b1; daq_write = 1'b1; daq_data = 16'h4052; clr_stat = 1'b1;
        @(negedge clk); sync = 1'b0; daq_write = 1'b0; clr_stat = 1'b0;
        idle(4);
        chk("t6_size", 32'(q_a.size()), 32'd3);
        chk("t6_ev",   32'(ev_a),       32'd0);
        chk("t6_drop", 32'(drop_a),     32'd0);
        chk("t6_ovf",  32'(overflow_a), 32'd0);
        q_a.delete();

        // 300-word event without trailer until the end: truncation at 256
        send(16'h8100);
        for (int i = 1; i <= 298; i++) begin
            d = 16'(i);
            send(d);
        end
        send(16'h412C);
        idle(4);
        chk("t7_size", 32'(q_a.size()), 32'd256);
        chk("t7_w254", 32'(qa_at(254)), 32'h0_00FE);
        chk("t7_w255", 32'(qa_at(255)), 32'h2_40FF);
        chk("t7_drop", 32'(drop_a),     32'd1);
        chk("t7_ovf",  32'(overflow_a), 32'd1);
        chk("t7_ev",   32'(ev_a),       32'd0);
        send(16'hC0EE); idle(4);
        chk("t7_next", 32'(qa_at(256)), 32'h3_C0EE);
        q_a.delete();

        // asynchronous reset in the middle of a stored event
        rdy_a = 1'b0;
        send(16'h8200); send(16'h0201); send(16'h0202); send(16'h0203); send(16'h0204);
        idle(2);
        chk("t8_fill",  32'(fill_a),      32'd5);
        chk("t8_valid", 32'(out_valid_a), 32'd1);
        chk("t8_head",  32'(out_data_a),  32'h8200);
        chk("t8_sop",   32'(out_sop_a),   32'd1);
        @(negedge clk); rst_a = 1'b0;
        #1;
        chk("t8_rvalid", 32'(out_valid_a), 32'd0);
        chk("t8_rfill",  32'(fill_a),      32'd0);
        chk("t8_rdata",  32'(out_data_a),  32'd0);
        chk("t8_rev",    32'(ev_a),        32'd0);
        chk("t8_rdrop",  32'(drop_a),      32'd0);
        chk("t8_rovf",   32'(overflow_a),  32'd0);
        @(negedge clk); rst_a = 1'b1; rdy_a = 1'b1;
        q_a.delete();
        send(16'h0205); send(16'h4206); idle(4);
        chk("t8_post_size", 32'(q_a.size()), 32'd0);
        chk("t8_post_ev",   32'(ev_a),       32'd0);

        // small FIFO: admission at free == MAX, rejection below it
        @(negedge clk); rst_b = 1'b1; rdy_b = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(16'h8001 | 16'(k << 8));
            send(16'h0002 | 16'(k << 8));
            send(16'h0003 | 16'(k << 8));
            send(16'h4004 | 16'(k << 8));
        end
        idle(2);
        chk("t9_fill",  32'(fill_b),      32'd12);
        chk("t9_ev",    32'(ev_b),        32'd3);
        chk("t9_drop",  32'(drop_b),      32'd1);
        chk("t9_ovf",   32'(overflow_b),  32'd1);
        chk("t9_valid", 32'(out_valid_b), 32'd1);
        chk("t9_head",  32'(out_data_b),  32'h8101);
        chk("t9_sop",   32'(out_sop_b),   32'd1);
        idle(3);
        chk("t9_stable", 32'(out_data_b), 32'h8101);
        rdy_b = 1'b1;
        idle(16);
        chk("t9_size", 32'(q_b.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            e[15:0] = 16'(((i / 4) + 1) << 8) | 16'((i % 4) + 1);
            if (i % 4 == 0) e[15:0] = e[15:0] | 16'h8000;
            if (i % 4 == 3) e[15:0] = e[15:0] | 16'h4000;
            e[16] = (i % 4 == 0);
            e[17] = (i % 4 == 3);
            chk($sformatf("t9_w%0d", i), 32'(qb_at(i)), 32'(e));
        end
        chk("t9_dfill",  32'(fill_b),      32'd0);
        chk("t9_dvalid", 32'(out_valid_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
